// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic phase sequencer.
// Phase encoding, lamp codes and default phase durations.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5
  } phase_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam int DEF_CW         = 6;
  localparam int DEF_NS_GREEN_S = 30;
  localparam int DEF_EW_GREEN_S = 15;
  localparam int DEF_YELLOW_S   = 4;
  localparam int DEF_ALLRED_S   = 2;

endpackage

// File: rtl/traffic_phase_fsm_phase_timer.sv
// Loadable down counter that stops at 1.
// expire flags the tick that lands on a remain of 1.
module phase_timer #(
  parameter int             CW      = 6,
  parameter logic [CW-1:0]  RST_VAL = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          tick,
  output logic [CW-1:0] remain,
  output logic          expire
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst)
      remain <= RST_VAL;
    else if (load)
      remain <= load_val;
    else if (tick && (remain > ONE))
      remain <= remain - ONE;
  end

  assign expire = tick && (remain == ONE);

endmodule

// File: rtl/traffic_phase_fsm.sv
// Traffic phase sequencer: NS main road, EW side road.
// Holds NS green until demand; latches pedestrian requests.
module traffic_phase_fsm
  import traffic_pkg::*;
#(
  parameter int CW         = DEF_CW,
  parameter int NS_GREEN_S = DEF_NS_GREEN_S,
  parameter int EW_GREEN_S = DEF_EW_GREEN_S,
  parameter int YELLOW_S   = DEF_YELLOW_S,
  parameter int ALLRED_S   = DEF_ALLRED_S
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          side_sensor,
  input  logic          ped_req,
  output logic [2:0]    ns_light,
  output logic [2:0]    ew_light,
  output logic          ped_walk,
  output logic          ped_pending,
  output logic [CW-1:0] seconds_left
);

  // Truncate to CW bits; a zero duration still lasts one tick.
  function automatic logic [CW-1:0] dur(input int unsigned s);
    logic [CW-1:0] t;
    t = s[CW-1:0];
    if (t == '0)
      t = {{(CW-1){1'b0}}, 1'b1};
    return t;
  endfunction

  localparam logic [CW-1:0] NS_D = dur(NS_GREEN_S);
  localparam logic [CW-1:0] EW_D = dur(EW_GREEN_S);
  localparam logic [CW-1:0] Y_D  = dur(YELLOW_S);
  localparam logic [CW-1:0] AR_D = dur(ALLRED_S);

  phase_t        state, state_d;
  logic          load;
  logic [CW-1:0] load_val;
  logic [CW-1:0] remain;
  logic          expire;
  logic          demand;
  logic          enter_ew;
  logic [2:0]    ns_d, ew_d;
  logic          walk_d;

  phase_timer #(
    .CW      (CW),
    .RST_VAL (NS_D)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .tick     (tick),
    .remain   (remain),
    .expire   (expire)
  );

  assign demand = side_sensor | ped_pending | ped_req;

  always_comb begin
    state_d  = state;
    load     = 1'b0;
    load_val = NS_D;
    if (expire) begin
      unique case (state)
        NS_GREEN: begin
          if (demand) begin
            state_d  = NS_YELLOW;
            load     = 1'b1;
            load_val = Y_D;
          end
        end
        NS_YELLOW: begin
          state_d  = ALLRED_A;
          load     = 1'b1;
          load_val = AR_D;
        end
        ALLRED_A: begin
          state_d  = EW_GREEN;
          load     = 1'b1;
          load_val = EW_D;
        end
        EW_GREEN: begin
          state_d  = EW_YELLOW;
          load     = 1'b1;
          load_val = Y_D;
        end
        EW_YELLOW: begin
          state_d  = ALLRED_B;
          load     = 1'b1;
          load_val = AR_D;
        end
        default: begin
          state_d  = NS_GREEN;
          load     = 1'b1;
          load_val = NS_D;
        end
      endcase
    end
  end

  assign enter_ew = (state_d == EW_GREEN)
                 && (state != EW_GREEN);

  always_ff @(posedge clk) begin
    if (rst)
      state <= NS_GREEN;
    else
      state <= state_d;
  end

  // Entry into EW green serves the request and beats a new one.
  always_ff @(posedge clk) begin
    if (rst)
      ped_pending <= 1'b0;
    else if (enter_ew)
      ped_pending <= 1'b0;
    else if (ped_req)
      ped_pending <= 1'b1;
  end

  always_comb begin
    ns_d   = LAMP_R;
    ew_d   = LAMP_R;
    walk_d = 1'b0;
    unique case (state)
      NS_GREEN:  ns_d = LAMP_G;
      NS_YELLOW: ns_d = LAMP_Y;
      EW_GREEN: begin
        ew_d   = LAMP_G;
        walk_d = 1'b1;
      end
      EW_YELLOW: ew_d = LAMP_Y;
      default: begin
        ns_d = LAMP_R;
        ew_d = LAMP_R;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ns_light     <= LAMP_G;
      ew_light     <= LAMP_R;
      ped_walk     <= 1'b0;
      seconds_left <= NS_D;
    end else begin
      ns_light     <= ns_d;
      ew_light     <= ew_d;
      ped_walk     <= walk_d;
      seconds_left <= remain;
    end
  end

  a_no_conflict: assert property (
    @(posedge clk) disable iff (rst)
    !((ns_light != LAMP_R) && (ew_light != LAMP_R))
  );

  a_one_hot: assert property (
    @(posedge clk) disable iff (rst)
    $onehot(ns_light) && $onehot(ew_light)
  );

endmodule

// File: doc/traffic_phase_fsm.md
Name: traffic_phase_fsm

Overview:
- Traffic-light phase sequencer for a main road (NS) and a side road (EW).
- Sits directly downstream of the 1 Hz enable divider and consumes its single-cycle `tick` pulse as its only time base.
- Advances through fixed-duration phases, holds NS green until demand appears, and latches pedestrian requests.
- Drives lamp outputs and a seconds-remaining value for the display stage.

Parameters:
- CW, 6, width of the seconds counter and of seconds_left
- NS_GREEN_S, 30, minimum NS green duration in ticks
- EW_GREEN_S, 15, EW green duration in ticks (also the walk duration)
- YELLOW_S, 4, yellow duration in ticks (both roads)
- ALLRED_S, 2, all-red clearance duration in ticks

Ports:
- clk, input, 1, system clock
- rst, input, 1, reset, synchronous, active-high
- tick, input, 1, 1 Hz enable from the divider; one-clk pulse
- side_sensor, input, 1, vehicle waiting on EW; level
- ped_req, input, 1, pedestrian button; may be a pulse of any length
- ns_light, output, 3, one-hot {R,Y,G} for NS
- ew_light, output, 3, one-hot {R,Y,G} for EW
- ped_walk, output, 1, walk signal for crossing NS
- ped_pending, output, 1, latched pedestrian request not yet served
- seconds_left, output, CW, ticks remaining in the current phase

Behaviour:
- States: NS_GREEN, NS_YELLOW, ALLRED_A, EW_GREEN, EW_YELLOW, ALLRED_B. Cycle order: NS_GREEN→NS_YELLOW→ALLRED_A→EW_GREEN→EW_YELLOW→ALLRED_B→NS_GREEN.
- Reset (rst=1 at a clk edge, any state, tick ignored):
  - state=NS_GREEN, remain=NS_GREEN_S, ped_pending=0
  - ns_light=001 (green), ew_light=100 (red), ped_walk=0
- Reset mid-phase takes effect on the same edge and abandons the phase.
- Timer and phase changes:
  - Without tick, state and remain hold.
  - On tick with remain>1: remain decrements.
  - On tick with remain==1: move to the next state and load that state's duration. Exception: NS_GREEN below.
- NS_GREEN hold:
  - demand = side_sensor | ped_pending | ped_req, evaluated in the tick cycle.
  - On tick with remain==1 and demand=0: stay in NS_GREEN with remain at 1.
  - The first tick with demand=1 then moves to NS_YELLOW.
- Pedestrian latch:
  - ped_pending sets on any cycle with ped_req=1.
  - It clears on the edge that enters EW_GREEN.
  - If ped_req=1 on that same edge, clear wins; the next request relatches.
  - While in EW_GREEN, new requests relatch for the next cycle.
- Outputs (registered, one-cycle latency after the state edge):
  - NS_GREEN: ns=001, ew=100
  - NS_YELLOW: ns=010, ew=100
  - ALLRED_A / ALLRED_B: ns=100, ew=100
  - EW_GREEN: ns=100, ew=001, ped_walk=1
  - EW_YELLOW: ns=100, ew=010
- seconds_left = remain, registered.
- Safety invariants (checked by assertions):
  - ns and ew are never both non-red.
  - Each light is always exactly one-hot.
- Width rules:
  - Durations are truncated to CW bits.
  - A duration of 0 is treated as 1; the phase lasts 1 tick.
  - remain never wraps below 1.
- tick high for several consecutive clks counts once per clk. The upstream divider guarantees single-cycle pulses.

Decomposition:
- Package traffic_pkg holds:
  - phase state enum (3 bits)
  - lamp constants LAMP_R=3'b100, LAMP_Y=3'b010, LAMP_G=3'b001
  - default duration localparams
- One sub-module, phase_timer: loadable CW-bit down counter with ports load, load_val, tick, remain, and expire = tick & (remain==1).
- The FSM, pedestrian latch and output decode stay in traffic_phase_fsm.

Test Plan:
- Test parameters for all scenarios: NS_GREEN_S=4, EW_GREEN_S=3, YELLOW_S=2, ALLRED_S=1, tick every 5 clks.
- Reset with side_sensor=1 → ns=001, ew=100, seconds_left=4. After ticks: NS_YELLOW after 4 ticks, ALLRED_A after 6, EW_GREEN after 7 (ew=001), EW_YELLOW after 10, ALLRED_B after 12, NS_GREEN after 13.
- side_sensor=0, no ped_req → NS_GREEN held; seconds_left stays 1 for 20 further ticks. Raise side_sensor → NS_YELLOW on the next tick.
- 1-clk ped_req pulse during NS_GREEN, sensor 0 → ped_pending=1. At expiry, sequence proceeds. ped_walk=1 for exactly 3 ticks in EW_GREEN. ped_pending=0 after EW_GREEN entry.
- ped_req asserted in the same clk as the expiry tick with no prior demand → transition taken that tick.
- rst pulsed mid-EW_GREEN with seconds_left=2 → next clk ns=001, ew=100, ped_walk=0, ped_pending=0, seconds_left=4.
- Random tick/sensor/ped stimulus for 10k clks → no overlapping non-red lamps; every light one-hot.
